ex_result_stage: RTL and testbench

- EX/MEM boundary register directly downstream of the 32-bit integer ALU.
- Captures ALU result, ALU error flag, destination register info and PC each cycle.
- Provides a 2-entry skid buffer with valid/ready handshake toward MEM, plus a pipeline flush.
- Converts ALU errors into a precise illegal-op exception and halts intake until flushed.

---
 rtl/ex_result_stage.sv | 150 +++++++++++++++
 tb/tb_ex_result_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_stage.sv
// EX/MEM result register with a 2-entry skid buffer toward MEM.
// Captures ALU result, error flag, rd info and PC; an ALU error becomes a precise exception that
// halts intake until flush. Optional forwarding lookup enabled by defining EX_RESULT_FWD_EN.
module ex_result_stage #(
  parameter int unsigned REGFILE_WIDTH = 32,
  parameter int unsigned REG_ADDR_W    = 5,
  parameter int unsigned ERRCNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REGFILE_WIDTH-1:0] alu_out,
  input  logic                     alu_err,
  input  logic [REG_ADDR_W-1:0]    rd_addr,
  input  logic                     rd_we,
  input  logic [REGFILE_WIDTH-1:0] pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REGFILE_WIDTH-1:0] out_result,
  output logic [REG_ADDR_W-1:0]    out_rd_addr,
  output logic                     out_rd_we,
  output logic [REGFILE_WIDTH-1:0] out_pc,
  output logic                     exc_valid,
  output logic                     halted,
  output logic [ERRCNT_W-1:0]      err_count
`ifdef EX_RESULT_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0]    fwd_rs_addr,
  output logic                     fwd_hit,
  output logic [REGFILE_WIDTH-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [REGFILE_WIDTH-1:0] res;
    logic [REG_ADDR_W-1:0]    rd;
    logic                     we;
    logic [REGFILE_WIDTH-1:0] pc;
    logic                     exc;
  } entry_t;

  entry_t                head_q, head_d, skid_q, skid_d, cap;
  logic                  head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic                  halted_q, halted_d, ready_q, ready_d;
  logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                  accept, pop;

  assign accept = in_valid & ready_q;
  assign pop    = head_vld_q & out_ready;

  // Capture transform: errored ops carry no result and never write rd; r0 is never written.
  always_comb begin
    cap.res = alu_err ? '0 : alu_out;
    cap.rd  = rd_addr;
    cap.we  = rd_we & (rd_addr != '0) & ~alu_err;
    cap.pc  = pc;
    cap.exc = alu_err;
  end

  // Next-state for head/skid occupancy, halt latch, error counter and registered ready.
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    halted_d   = halted_q;
    err_cnt_d  = err_cnt_q;
    if (flush) begin
      // Flush beats both accept and pop; data fields simply hold.
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      halted_d   = 1'b0;
    end else begin
      if (pop) begin
        if (skid_vld_q) begin
          head_d     = skid_q;
          skid_vld_d = 1'b0;
        end else begin
          head_vld_d = 1'b0;
        end
      end
      // head_vld_d already reflects the pop, so this picks head vs skid correctly.
      if (accept) begin
        if (head_vld_d) begin
          skid_d     = cap;
          skid_vld_d = 1'b1;
        end else begin
          head_d     = cap;
          head_vld_d = 1'b1;
        end
        if (alu_err) begin
          halted_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
      end
    end
    ready_d = ~skid_vld_d & ~halted_d;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      halted_q   <= 1'b0;
      err_cnt_q  <= '0;
      ready_q    <= 1'b1;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      halted_q   <= halted_d;
      err_cnt_q  <= err_cnt_d;
      ready_q    <= ready_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = head_vld_q;
  assign out_result  = head_q.res;
  assign out_rd_addr = head_q.rd;
  assign out_rd_we   = head_q.we;
  assign out_pc      = head_q.pc;
  assign exc_valid   = head_vld_q & head_q.exc;
  assign halted      = halted_q;
  assign err_count   = err_cnt_q;

`ifdef EX_RESULT_FWD_EN
  // Forwarding lookup; the skid entry is younger, so it wins over the head.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs_addr != '0) begin
      if (skid_vld_q && !skid_q.exc && skid_q.we && (skid_q.rd == fwd_rs_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = skid_q.res;
      end else if (head_vld_q && !head_q.exc && head_q.we && (head_q.rd == fwd_rs_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = head_q.res;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Randomized self-checking bench for ex_result_stage against a queue-based reference model.
module tb_ex_result_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready, alu_err, rd_we, flush;
  logic [31:0] alu_out, pc;
  logic [4:0]  rd_addr;
  logic        out_valid, out_ready, out_rd_we, exc_valid, halted;
  logic [31:0] out_result, out_pc;
  logic [4:0]  out_rd_addr;
  logic [7:0]  err_count;
`ifdef EX_RESULT_FWD_EN
  logic [4:0]  fwd_rs_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  ex_result_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_err(alu_err), .rd_addr(rd_addr), .rd_we(rd_we), .pc(pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_pc(out_pc),
    .exc_valid(exc_valid), .halted(halted), .err_count(err_count)
`ifdef EX_RESULT_FWD_EN
    , .fwd_rs_addr(fwd_rs_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held ops plus a halt bit and an error tally.
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
    logic        exc;
  } ent_t;

  ent_t q[$];
  ent_t m_last;
  bit   m_known;
  bit   m_halted;
  int   m_errs;

  function automatic bit m_ready();
    return (q.size() < 2) && !m_halted;
  endfunction

  task automatic model_reset();
    q.delete();
    m_last   = '{res: 0, rd: 0, we: 0, pc: 0, exc: 0};
    m_known  = 1;
    m_halted = 0;
    m_errs   = 0;
  endtask

  task automatic model_step();
    bit   acc, pp;
    ent_t e;
    acc = in_valid && m_ready();
    pp  = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
      m_halted = 0;
      m_known  = 0;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.res = alu_err ? 32'd0 : alu_out;
        e.rd  = rd_addr;
        e.we  = rd_we && (rd_addr != 0) && !alu_err;
        e.pc  = pc;
        e.exc = alu_err;
        q.push_back(e);
        if (alu_err) begin
          m_halted = 1;
          if (m_errs < 255) m_errs++;
        end
      end
    end
    if (q.size() > 0) begin
      m_last  = q[0];
      m_known = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("out_valid", out_valid, q.size() > 0);
    check_eq("exc_valid", exc_valid, (q.size() > 0) && q[0].exc);
    check_eq("halted", halted, m_halted);
    check_eq("in_ready", in_ready, m_ready());
    check_eq("err_count", err_count, m_errs);
    if (m_known) begin
      check_eq("out_result", out_result, m_last.res);
      check_eq("out_rd_addr", out_rd_addr, m_last.rd);
      check_eq("out_rd_we", out_rd_we, m_last.we);
      check_eq("out_pc", out_pc, m_last.pc);
    end
`ifdef EX_RESULT_FWD_EN
    begin
      bit          hit;
      logic [31:0] dat;
      hit = 0;
      dat = 0;
      if (fwd_rs_addr != 0) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (!q[i].exc && q[i].we && q[i].rd == fwd_rs_addr) begin
            hit = 1;
            dat = q[i].res;
            break;
          end
        end
      end
      check_eq("fwd_hit", fwd_hit, hit);
      check_eq("fwd_data", fwd_data, dat);
    end
`endif
  endtask

  // Inputs are set just after an edge, then the next edge is taken and outputs sampled #1 later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic step(input logic iv, input logic er, input logic [31:0] res,
                      input logic [4:0] rd, input logic we, input logic [31:0] p,
                      input logic ordy, input logic fl);
    in_valid  = iv;
    alu_err   = er;
    alu_out   = res;
    rd_addr   = rd;
    rd_we     = we;
    pc        = p;
    out_ready = ordy;
    flush     = fl;
    cycle();
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0; alu_err = 0; alu_out = 0; rd_addr = 0; rd_we = 0; pc = 0;
    out_ready = 0; flush = 0;
`ifdef EX_RESULT_FWD_EN
    fwd_rs_addr = 0;
`endif
    model_reset();
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_out_result", out_result, 0);
    check_eq("rst_out_pc", out_pc, 0);
    rst_n = 1;
    #4;

    // Basic flow
    step(1, 0, 32'h1234, 5'd3, 1, 32'h100, 1, 0);
    check_eq("basic_valid", out_valid, 1);
    check_eq("basic_result", out_result, 32'h1234);
    check_eq("basic_rd", out_rd_addr, 3);
    check_eq("basic_we", out_rd_we, 1);
    check_eq("basic_pc", out_pc, 32'h100);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    // Backpressure: A to head, B to skid, C refused
    step(1, 0, 32'hA, 5'd1, 1, 32'h10, 0, 0);
    step(1, 0, 32'hB, 5'd2, 1, 32'h14, 0, 0);
    check_eq("bp_ready_low", in_ready, 0);
    step(1, 0, 32'hC, 5'd3, 1, 32'h18, 0, 0);
    check_eq("bp_head_a", out_result, 32'hA);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("bp_head_b", out_result, 32'hB);
    check_eq("bp_ready_back", in_ready, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("bp_empty", out_valid, 0);

    // Error capture
    step(1, 1, 32'hDEAD, 5'd5, 1, 32'h200, 0, 0);
    check_eq("err_exc", exc_valid, 1);
    check_eq("err_result", out_result, 0);
    check_eq("err_we", out_rd_we, 0);
    check_eq("err_halted", halted, 1);
    check_eq("err_ready", in_ready, 0);
    check_eq("err_count1", err_count, 1);
    check_eq("err_pc", out_pc, 32'h200);

    // Flush with simultaneous input
    step(1, 0, 32'h5555, 5'd6, 1, 32'h300, 0, 1);
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_halted", halted, 0);
    check_eq("fl_ready", in_ready, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("fl_dropped", out_valid, 0);
    check_eq("fl_errcnt", err_count, 1);

    // Saturation
    for (int i = 0; i < 256; i++) begin
      step(1, 1, i, 5'd7, 1, i, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
    end
    check_eq("sat_count", err_count, 8'hFF);

    // r0 write suppressed
    step(1, 0, 32'h77, 5'd0, 1, 32'h400, 1, 0);
    check_eq("r0_we", out_rd_we, 0);
    check_eq("r0_valid", out_valid, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);

`ifdef EX_RESULT_FWD_EN
    step(1, 0, 32'h11, 5'd4, 1, 32'h500, 0, 0);
    step(1, 0, 32'h22, 5'd4, 1, 32'h504, 0, 0);
    fwd_rs_addr = 5'd4;
    #1;
    check_eq("fwd_hit_skid", fwd_hit, 1);
    check_eq("fwd_data_skid", fwd_data, 32'h22);
    fwd_rs_addr = 5'd0;
    #1;
    check_eq("fwd_hit_r0", fwd_hit, 0);
    check_eq("fwd_data_r0", fwd_data, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
`ifdef EX_RESULT_FWD_EN
      fwd_rs_addr = 5'($urandom_range(0, 7));
`endif
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom,
           5'($urandom_range(0, 7)), 1'($urandom), $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset with data in flight
    step(1, 0, 32'h99, 5'd9, 1, 32'h600, 0, 0);
    step(1, 0, 32'h98, 5'd9, 1, 32'h604, 0, 0);
    rst_n = 0;
    #1;
    model_reset();
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    check_eq("mid_rst_errcnt", err_count, 0);
    check_eq("mid_rst_result", out_result, 0);
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 32'h42, 5'd2, 1, 32'h700, 1, 0);
    check_eq("post_rst_result", out_result, 32'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
